// File: rtl/deser_fifo.sv
// deser_fifo: serial-to-parallel receiver feeding a DEPTH-word output FIFO.
// Bits are placed LSB-first or MSB-first into a word buffer; each completed
// word is pushed to the FIFO tail, and the consumer pops the head with ack_in.
module deser_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       clock_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  output logic                       status_out,
  output logic                       data_ready,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       ack_in,
  output logic [$clog2(DEPTH):0]     fill_out,
  output logic                       overflow
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [BW-1:0]    r_bcnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_status;
  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_push;
  logic             w_pop;
  logic [BW-1:0]    w_idx;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_word;

  // Handshake and completion decode, all from registered state plus inputs.
  always_comb begin
    w_status = (r_count != CW'(DEPTH));
    w_ready  = (r_count != '0);
    w_accept = write_in && w_status;
    w_last   = (r_bcnt == BW'(WIDTH - 1));
    w_push   = w_accept && w_last;
    w_pop    = ack_in && w_ready;
    w_idx    = MSB_FIRST ? (BW'(WIDTH - 1) - r_bcnt) : r_bcnt;
    w_bit    = '0;
    w_bit[w_idx] = data_in;
    // Word as it will be after this bit lands; used when the word completes.
    w_word   = r_shift | w_bit;
  end

  // Word assembly: place accepted bits, clear on completion.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_bcnt  <= '0;
      r_shift <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_bcnt  <= '0;
        r_shift <= '0;
      end else begin
        r_bcnt  <= r_bcnt + 1'b1;
        r_shift <= w_word;
      end
    end
  end

  // FIFO storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock_100KHz) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a bit offered while the FIFO is full is dropped.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (write_in && !w_status) begin
      r_overflow <= 1'b1;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    status_out = w_status;
    data_ready = w_ready;
    data_out   = w_ready ? r_mem[r_rptr] : '0;
    fill_out   = r_count;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_deser_fifo.sv
// Bench for deser_fifo: LSB-first and MSB-first instances share stimulus; a
// queue-based model predicts both and is compared every cycle, plus literal
// expectations from hand-computed scenarios.
module tb_deser_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             data_in;
  logic             write_in;
  logic             ack_in;

  logic             st_l, rdy_l, ovf_l;
  logic [WIDTH-1:0] dout_l;
  logic [2:0]       fill_l;
  logic             st_m, rdy_m, ovf_m;
  logic [WIDTH-1:0] dout_m;
  logic [2:0]       fill_m;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
    .clock_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(st_l), .data_ready(rdy_l), .data_out(dout_l), .ack_in(ack_in),
    .fill_out(fill_l), .overflow(ovf_l)
  );

  deser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
    .clock_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .status_out(st_m), .data_ready(rdy_m), .data_out(dout_m), .ack_in(ack_in),
    .fill_out(fill_m), .overflow(ovf_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: list of received bits, word queues, sticky flag.
  bit          m_bits[$];
  logic [7:0]  m_q_l[$];
  logic [7:0]  m_q_m[$];
  bit          m_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bits.delete();
      m_q_l.delete();
      m_q_m.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit can_take = (m_q_l.size() != DEPTH);
      automatic bit do_pop   = ack_in && (m_q_l.size() != 0);
      if (write_in && !can_take) m_ovf = 1'b1;
      if (do_pop) begin
        void'(m_q_l.pop_front());
        void'(m_q_m.pop_front());
      end
      if (write_in && can_take) begin
        m_bits.push_back(data_in);
        if (m_bits.size() == WIDTH) begin
          automatic logic [7:0] wl = '0;
          automatic logic [7:0] wm = '0;
          for (int i = 0; i < WIDTH; i++) begin
            wl[i]           = m_bits[i];
            wm[WIDTH-1-i]   = m_bits[i];
          end
          m_q_l.push_back(wl);
          m_q_m.push_back(wm);
          m_bits.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int unsigned sz = m_q_l.size();
      check("cyc_status_l", {31'd0, st_l}, {31'd0, sz != DEPTH});
      check("cyc_ready_l",  {31'd0, rdy_l}, {31'd0, sz != 0});
      check("cyc_fill_l",   {29'd0, fill_l}, sz);
      check("cyc_dout_l",   {24'd0, dout_l}, (sz != 0) ? {24'd0, m_q_l[0]} : 32'd0);
      check("cyc_ovf_l",    {31'd0, ovf_l}, {31'd0, m_ovf});
      check("cyc_status_m", {31'd0, st_m}, {31'd0, sz != DEPTH});
      check("cyc_fill_m",   {29'd0, fill_m}, sz);
      check("cyc_dout_m",   {24'd0, dout_m}, (sz != 0) ? {24'd0, m_q_m[0]} : 32'd0);
      check("cyc_ovf_m",    {31'd0, ovf_m}, {31'd0, m_ovf});
    end
  end

  // Record every word popped from the LSB instance.
  logic [7:0] popped[$];
  always @(negedge clk) begin
    if (reset && ack_in && rdy_l) popped.push_back(dout_l);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Drive one word LSB-first (bit i of w on cycle i).
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      data_in  = w[i];
      write_in = 1'b1;
      cyc();
    end
    write_in = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
    #1;
    check("rst_status", {31'd0, st_l}, 32'd1);
    check("rst_ready",  {31'd0, rdy_l}, 32'd0);
    check("rst_fill",   {29'd0, fill_l}, 32'd0);
    cyc(2);
    reset = 1'b1;
    chk_en = 1'b1;
    cyc();

    // LSB-first / MSB-first word: bits 1,0,1,1,0,0,1,0.
    send_word(8'h4D);
    check("w1_ready", {31'd0, rdy_l}, 32'd1);
    check("w1_lsb",   {24'd0, dout_l}, 32'h4D);
    check("w1_msb",   {24'd0, dout_m}, 32'hB2);
    check("w1_fill",  {29'd0, fill_l}, 32'd1);
    ack_in = 1'b1; cyc(); ack_in = 1'b0;
    check("w1_pop_ready", {31'd0, rdy_l}, 32'd0);
    check("w1_pop_dout",  {24'd0, dout_l}, 32'd0);

    // Fill to full, overflow, then one pop.
    send_word(8'hA5); send_word(8'h3C); send_word(8'hFF); send_word(8'h01);
    check("full_fill",   {29'd0, fill_l}, 32'd4);
    check("full_status", {31'd0, st_l}, 32'd0);
    check("full_head",   {24'd0, dout_l}, 32'hA5);
    data_in = 1'b1; write_in = 1'b1; cyc(); write_in = 1'b0;
    check("ovf_set",     {31'd0, ovf_l}, 32'd1);
    check("ovf_fill",    {29'd0, fill_l}, 32'd4);
    ack_in = 1'b1; cyc(); ack_in = 1'b0;
    check("pop_status",  {31'd0, st_l}, 32'd1);
    check("pop_head",    {24'd0, dout_l}, 32'h3C);
    check("pop_fill",    {29'd0, fill_l}, 32'd3);
    ack_in = 1'b1; cyc(3); ack_in = 1'b0;
    check("drain_fill",  {29'd0, fill_l}, 32'd0);

    // Dropped bit must not have advanced the bit counter.
    send_word(8'h5A);
    check("post_ovf_word", {24'd0, dout_l}, 32'h5A);
    check("ovf_sticky",    {31'd0, ovf_l}, 32'd1);
    ack_in = 1'b1; cyc(); ack_in = 1'b0;

    // Simultaneous push and pop.
    send_word(8'h11);
    for (int i = 0; i < WIDTH; i++) begin
      data_in  = 1'(8'h22 >> i);
      write_in = 1'b1;
      ack_in   = (i == WIDTH - 1);
      cyc();
    end
    write_in = 1'b0; ack_in = 1'b0;
    check("pp_fill", {29'd0, fill_l}, 32'd1);
    check("pp_dout", {24'd0, dout_l}, 32'h22);
    ack_in = 1'b1; cyc(); ack_in = 1'b0;

    // Pointer wrap: 10 back-to-back words with ack held high.
    popped.delete();
    ack_in = 1'b1;
    for (int k = 0; k < 10; k++) send_word(8'(8'h30 + k * 8'h07));
    cyc(2);
    ack_in = 1'b0;
    check("wrap_count", popped.size(), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < popped.size())
        check("wrap_word", {24'd0, popped[k]}, {24'd0, 8'(8'h30 + k * 8'h07)});
    end
    check("wrap_fill", {29'd0, fill_l}, 32'd0);

    // Mid-word asynchronous reset with two words queued.
    send_word(8'hC3); send_word(8'h0F);
    for (int i = 0; i < 5; i++) begin
      data_in = 1'b1; write_in = 1'b1; cyc();
    end
    write_in = 1'b0;
    check("pre_rst_fill", {29'd0, fill_l}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("arst_ready",  {31'd0, rdy_l}, 32'd0);
    check("arst_fill",   {29'd0, fill_l}, 32'd0);
    check("arst_status", {31'd0, st_l}, 32'd1);
    check("arst_dout",   {24'd0, dout_l}, 32'd0);
    check("arst_ovf",    {31'd0, ovf_l}, 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc();
    send_word(8'h96);
    check("after_rst_lsb",  {24'd0, dout_l}, 32'h96);
    check("after_rst_msb",  {24'd0, dout_m}, 32'h69);
    check("after_rst_fill", {29'd0, fill_l}, 32'd1);
    cyc(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
